// File: rtl/proc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// proc_ctrl_fsm
//
// Control sequencer for the 9-bit processor datapath. An instruction word is
// captured from din when run is seen in IDLE, then stepped through T1..T3.
// Each step drives the one-hot bus-source selects and the matching destination
// load enables, so every register transfer on the shared bus originates here.
//
// Instruction format: ir[8:6] = opcode, ir[5:3] = X, ir[2:0] = Y
//   000 mv  Rx,Ry   001 mvi Rx,#D   010 add Rx,Ry   011 sub Rx,Ry
//   anything else is a NOP that completes in T1.
//
// Ports
//   clock   in   rising-edge system clock
//   reset   in   synchronous active-high reset, clears all state
//   run     in   start request, only looked at in IDLE
//   din     in   instruction word in IDLE (immediate data uses dsele instead)
//   rsele   out  one-hot bus source select R0..R7
//   gsele   out  bus source = G (ALU result register)
//   dsele   out  bus source = din
//   rin     out  one-hot load enable R0..R7
//   ain     out  load A from bus
//   gin     out  load G from ALU
//   addsub  out  ALU op, 0 = add, 1 = subtract
//   done    out  instruction completes this cycle
//   ir      out  current instruction register
//   tstep   out  current step, 0 = IDLE, 1..3 = T1..T3
// ---------------------------------------------------------------------------
module proc_ctrl_fsm #(
  parameter int OPW = 3,
  parameter int RW  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic [OPW+2*RW-1:0]   din,
  output logic [(2**RW)-1:0]    rsele,
  output logic                  gsele,
  output logic                  dsele,
  output logic [(2**RW)-1:0]    rin,
  output logic                  ain,
  output logic                  gin,
  output logic                  addsub,
  output logic                  done,
  output logic [OPW+2*RW-1:0]   ir,
  output logic [1:0]            tstep
);

  localparam int IW = OPW + 2*RW;
  localparam int NR = 2**RW;

  localparam logic [OPW-1:0] OP_MV  = OPW'(0);
  localparam logic [OPW-1:0] OP_MVI = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(2);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    T1   = 2'd1,
    T2   = 2'd2,
    T3   = 2'd3
  } step_t;

  // Full set of control outputs, kept together so they can be registered as
  // one word alongside the step counter.
  typedef struct packed {
    logic [NR-1:0] rsele;
    logic          gsele;
    logic          dsele;
    logic [NR-1:0] rin;
    logic          ain;
    logic          gin;
    logic          addsub;
    logic          done;
  } ctrl_t;

  step_t         state;
  step_t         state_next;
  logic [IW-1:0] ir_q;
  logic [IW-1:0] ir_next;
  ctrl_t         ctrl_q;

  // Only add and sub need the three-step A / G / writeback sequence.
  function automatic logic is_arith(input logic [OPW-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Control word for a given step and instruction. This is the Moore output
  // decode: it only ever sees the step and the instruction register, never
  // run or din directly.
  function automatic ctrl_t decode(input step_t s, input logic [IW-1:0] i);
    ctrl_t         c;
    logic [OPW-1:0] op;
    logic [RW-1:0]  x;
    logic [RW-1:0]  y;
    c  = '0;
    op = i[IW-1 -: OPW];
    x  = i[2*RW-1 -: RW];
    y  = i[RW-1:0];
    case (s)
      T1: begin
        case (op)
          OP_MV: begin
            c.rsele = NR'(1) << y;
            c.rin   = NR'(1) << x;
            c.done  = 1'b1;
          end
          OP_MVI: begin
            c.dsele = 1'b1;
            c.rin   = NR'(1) << x;
            c.done  = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            c.rsele = NR'(1) << x;
            c.ain   = 1'b1;
          end
          default: begin
            c.done = 1'b1;
          end
        endcase
      end
      T2: begin
        if (is_arith(op)) begin
          c.rsele  = NR'(1) << y;
          c.gin    = 1'b1;
          c.addsub = op[0];
        end
      end
      T3: begin
        if (is_arith(op)) begin
          c.gsele = 1'b1;
          c.rin   = NR'(1) << x;
          c.done  = 1'b1;
        end
      end
      default: begin
        c = '0;
      end
    endcase
    return c;
  endfunction

  // Next step and next instruction register. The instruction is only
  // captured on the edge that leaves IDLE, so ir stays stable for the whole
  // instruction and run is ignored while one is in flight.
  always_comb begin
    state_next = state;
    ir_next    = ir_q;
    case (state)
      IDLE: begin
        if (run) begin
          state_next = T1;
          ir_next    = din;
        end
      end
      T1: begin
        state_next = is_arith(ir_q[IW-1 -: OPW]) ? T2 : IDLE;
      end
      T2: begin
        state_next = T3;
      end
      T3: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, instruction and control word are all registered together. The
  // control word is decoded from the values the state and ir are about to
  // take, so it always matches the step that is current after the edge.
  // Reset wins over everything, which also drops done for an aborted add/sub.
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      ir_q   <= '0;
      ctrl_q <= '0;
    end else begin
      state  <= state_next;
      ir_q   <= ir_next;
      ctrl_q <= decode(state_next, ir_next);
    end
  end

  assign rsele  = ctrl_q.rsele;
  assign gsele  = ctrl_q.gsele;
  assign dsele  = ctrl_q.dsele;
  assign rin    = ctrl_q.rin;
  assign ain    = ctrl_q.ain;
  assign gin    = ctrl_q.gin;
  assign addsub = ctrl_q.addsub;
  assign done   = ctrl_q.done;
  assign ir     = ir_q;
  assign tstep  = state;

  // Bus-level sanity: a single driver on the bus, a single destination, the
  // ALU op only meaningful in T2, and done only on an instruction's last step.
  assert property (@(posedge clock) disable iff (reset)
    $onehot0({rsele, gsele, dsele}));
  assert property (@(posedge clock) disable iff (reset)
    $onehot0(rin));
  assert property (@(posedge clock) disable iff (reset)
    addsub |-> (state == T2));
  assert property (@(posedge clock) disable iff (reset)
    done |-> ((state == T3) || ((state == T1) && !is_arith(ir_q[IW-1 -: OPW]))));

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_proc_ctrl_fsm
//
// Self-checking bench for proc_ctrl_fsm. A table of directed cycles walks
// through reset, mvi, mv, sub, back-to-back add/mv, NOP and run/din being
// ignored mid-instruction. A hand-written sequence aborts an add in T2. Then
// random run/din/reset traffic is compared against a reference model that
// expands each accepted instruction into its list of bus transfers.
// ---------------------------------------------------------------------------
module tb_proc_ctrl_fsm;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run   = 1'b0;
  logic [8:0] din   = 9'h000;
  logic [7:0] rsele;
  logic       gsele;
  logic       dsele;
  logic [7:0] rin;
  logic       ain;
  logic       gin;
  logic       addsub;
  logic       done;
  logic [8:0] ir;
  logic [1:0] tstep;

  proc_ctrl_fsm #(.OPW(3), .RW(3)) dut (
    .clock  (clock),
    .reset  (reset),
    .run    (run),
    .din    (din),
    .rsele  (rsele),
    .gsele  (gsele),
    .dsele  (dsele),
    .rin    (rin),
    .ain    (ain),
    .gin    (gin),
    .addsub (addsub),
    .done   (done),
    .ir     (ir),
    .tstep  (tstep)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0] tstep;
    logic [8:0] ir;
    logic [7:0] rsele;
    logic       gsele;
    logic       dsele;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic       addsub;
    logic       done;
  } exp_t;

  typedef struct {
    logic       rst;
    logic       run;
    logic [8:0] din;
    exp_t       exp;
  } vec_t;

  vec_t       vecs[$];
  exp_t       model_q[$];
  logic [8:0] model_ir;
  int         checks = 0;
  int         fails  = 0;

  function automatic exp_t idle_exp(input logic [8:0] i);
    exp_t e;
    e    = '0;
    e.ir = i;
    return e;
  endfunction

  function automatic exp_t step_exp(input logic [1:0] t, input logic [8:0] i,
                                    input logic [7:0] rs, input logic g,
                                    input logic d, input logic [7:0] ri,
                                    input logic a, input logic gi,
                                    input logic as, input logic dn);
    exp_t e;
    e.tstep  = t;
    e.ir     = i;
    e.rsele  = rs;
    e.gsele  = g;
    e.dsele  = d;
    e.rin    = ri;
    e.ain    = a;
    e.gin    = gi;
    e.addsub = as;
    e.done   = dn;
    return e;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("tstep=%0d ir=%h rsele=%h gsele=%b dsele=%b rin=%h ain=%b gin=%b addsub=%b done=%b",
                     e.tstep, e.ir, e.rsele, e.gsele, e.dsele, e.rin,
                     e.ain, e.gin, e.addsub, e.done);
  endfunction

  function automatic exp_t observed();
    exp_t e;
    e.tstep  = tstep;
    e.ir     = ir;
    e.rsele  = rsele;
    e.gsele  = gsele;
    e.dsele  = dsele;
    e.rin    = rin;
    e.ain    = ain;
    e.gin    = gin;
    e.addsub = addsub;
    e.done   = done;
    return e;
  endfunction

  task automatic addVec(input logic r, input logic rn, input logic [8:0] d,
                        input exp_t e);
    vec_t v;
    v.rst = r;
    v.run = rn;
    v.din = d;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic rn, input logic [8:0] d);
    reset = r;
    run   = rn;
    din   = d;
  endtask

  task automatic checkOutput(input string name, input exp_t want);
    exp_t got;
    got = observed();
    checks++;
    if (got !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %s, required %s", name, fmt(got), fmt(want));
    end
  endtask

  // Every cycle: one bus driver, one destination, addsub only in T2.
  task automatic checkInvariants(input string name);
    checks++;
    if (!($onehot0({rsele, gsele, dsele}) && $onehot0(rin) &&
          (!addsub || tstep == 2'd2))) begin
      fails++;
      $display("[TB] FAIL %s invariant: got rsele=%h gsele=%b dsele=%b rin=%h addsub=%b tstep=%0d, required one-hot0 source, one-hot0 rin, addsub only in T2",
               name, rsele, gsele, dsele, rin, addsub, tstep);
    end
  endtask

  // Reference model: an accepted instruction becomes the list of bus
  // transfers it performs, one entry per cycle after the run edge.
  task automatic plan(input logic [8:0] i);
    logic [2:0] op;
    logic [7:0] rx;
    logic [7:0] ry;
    op = i[8:6];
    rx = 8'h01 << i[5:3];
    ry = 8'h01 << i[2:0];
    if (op == 3'd0) begin
      model_q.push_back(step_exp(2'd1, i, ry, 1'b0, 1'b0, rx, 1'b0, 1'b0, 1'b0, 1'b1));
    end else if (op == 3'd1) begin
      model_q.push_back(step_exp(2'd1, i, 8'h00, 1'b0, 1'b1, rx, 1'b0, 1'b0, 1'b0, 1'b1));
    end else if (op == 3'd2 || op == 3'd3) begin
      model_q.push_back(step_exp(2'd1, i, rx, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
      model_q.push_back(step_exp(2'd2, i, ry, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, op == 3'd3, 1'b0));
      model_q.push_back(step_exp(2'd3, i, 8'h00, 1'b1, 1'b0, rx, 1'b0, 1'b0, 1'b0, 1'b1));
    end else begin
      model_q.push_back(step_exp(2'd1, i, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    end
  endtask

  initial begin
    logic       r_rst;
    logic       r_run;
    logic [8:0] r_din;
    exp_t       cur;

    // Directed table: inputs held during one cycle, outputs expected after it.
    addVec(1'b1, 1'b0, 9'h000, idle_exp(9'h000));
    addVec(1'b1, 1'b0, 9'h000, idle_exp(9'h000));
    for (int k = 0; k < 5; k++) addVec(1'b0, 1'b0, 9'h0AB, idle_exp(9'h000));
    // mvi R2,#0x15
    addVec(1'b0, 1'b1, 9'h050, step_exp(2'd1, 9'h050, 8'h00, 1'b0, 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1));
    addVec(1'b0, 1'b0, 9'h015, idle_exp(9'h050));
    // mv R5,R2
    addVec(1'b0, 1'b1, 9'h02A, step_exp(2'd1, 9'h02A, 8'h04, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1));
    addVec(1'b0, 1'b0, 9'h000, idle_exp(9'h02A));
    // sub R1,R6
    addVec(1'b0, 1'b1, 9'h0CE, step_exp(2'd1, 9'h0CE, 8'h02, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    addVec(1'b0, 1'b0, 9'h000, step_exp(2'd2, 9'h0CE, 8'h40, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0));
    addVec(1'b0, 1'b0, 9'h000, step_exp(2'd3, 9'h0CE, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1));
    addVec(1'b0, 1'b0, 9'h000, idle_exp(9'h0CE));
    // add R0,R1 then mv R3,R3 with run held high
    addVec(1'b0, 1'b1, 9'h081, step_exp(2'd1, 9'h081, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    addVec(1'b0, 1'b1, 9'h01B, step_exp(2'd2, 9'h081, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    addVec(1'b0, 1'b1, 9'h01B, step_exp(2'd3, 9'h081, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1));
    addVec(1'b0, 1'b1, 9'h01B, idle_exp(9'h081));
    addVec(1'b0, 1'b1, 9'h01B, step_exp(2'd1, 9'h01B, 8'h08, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1));
    addVec(1'b0, 1'b0, 9'h000, idle_exp(9'h01B));
    // reserved opcode runs as NOP
    addVec(1'b0, 1'b1, 9'h180, step_exp(2'd1, 9'h180, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1));
    addVec(1'b0, 1'b0, 9'h000, idle_exp(9'h180));
    // add R4,R7 with run/din wiggling mid-instruction
    addVec(1'b0, 1'b1, 9'h0A7, step_exp(2'd1, 9'h0A7, 8'h10, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    addVec(1'b0, 1'b1, 9'h1FF, step_exp(2'd2, 9'h0A7, 8'h80, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    addVec(1'b0, 1'b0, 9'h050, step_exp(2'd3, 9'h0A7, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1));
    addVec(1'b0, 1'b1, 9'h050, idle_exp(9'h0A7));
    // reset beats run in IDLE
    addVec(1'b1, 1'b1, 9'h081, idle_exp(9'h000));
    addVec(1'b0, 1'b0, 9'h000, idle_exp(9'h000));

    $display("[TB] directed table, %0d vectors", vecs.size());
    @(negedge clock);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].run, vecs[i].din);
      @(posedge clock);
      @(negedge clock);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      checkInvariants($sformatf("vec%0d", i));
    end

    // Abort an add in T2: reset must return to IDLE with ir cleared, no done.
    $display("[TB] abort sequence");
    applyStimulus(1'b0, 1'b1, 9'h081);
    @(posedge clock); @(negedge clock);
    checkOutput("abort_t1", step_exp(2'd1, 9'h081, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0));
    applyStimulus(1'b0, 1'b0, 9'h000);
    @(posedge clock); @(negedge clock);
    checkOutput("abort_t2", step_exp(2'd2, 9'h081, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    applyStimulus(1'b1, 1'b0, 9'h000);
    @(posedge clock); @(negedge clock);
    checkOutput("abort_reset", idle_exp(9'h000));
    applyStimulus(1'b0, 1'b0, 9'h000);
    @(posedge clock); @(negedge clock);
    checkOutput("abort_after", idle_exp(9'h000));

    // Random traffic against the transfer-list model.
    $display("[TB] random traffic");
    applyStimulus(1'b1, 1'b0, 9'h000);
    @(posedge clock); @(negedge clock);
    model_q.delete();
    model_ir = 9'h000;
    for (int n = 0; n < 3000; n++) begin
      cur = (model_q.size() > 0) ? model_q[0] : idle_exp(model_ir);
      checkOutput($sformatf("rand%0d", n), cur);
      checkInvariants($sformatf("rand%0d", n));
      r_rst = ($urandom_range(0, 39) == 0);
      r_run = 1'($urandom_range(0, 1));
      r_din = 9'($urandom);
      applyStimulus(r_rst, r_run, r_din);
      if (r_rst) begin
        model_q.delete();
        model_ir = 9'h000;
      end else if (model_q.size() > 0) begin
        void'(model_q.pop_front());
      end else if (r_run) begin
        model_ir = r_din;
        plan(r_din);
      end
      @(posedge clock);
      @(negedge clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/proc_ctrl_fsm.md
# proc_ctrl_fsm

Control sequencer for the 9-bit processor datapath. It fetches a 9-bit instruction from `din`, decodes it, and steps through T1–T3. Each step drives the one-hot bus-source selects consumed by the bus multiplexer (`rsele`, `gsele`, `dsele`) and the matching destination load enables (`rin`, `ain`, `gin`). Every register transfer on the shared bus originates here.

## Interface
Parameters
- `OPW`, 3, opcode field width
- `RW`, 3, register-index field width (8 registers)

Ports
- `clock`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all state
- `run`  in  1  start request, sampled only in IDLE
- `din`  in  9  instruction word in IDLE; immediate data is driven onto the bus via `dsele`
- `rsele`  out  8  one-hot source select, R0..R7
- `gsele`  out  1  select G (ALU result register) as bus source
- `dsele`  out  1  select `din` as bus source
- `rin`  out  8  one-hot load enable, R0..R7
- `ain`  out  1  load A from bus
- `gin`  out  1  load G from ALU
- `addsub`  out  1  ALU op: 0 = add, 1 = subtract
- `done`  out  1  instruction completes this cycle
- `ir`  out  9  current instruction register (debug)
- `tstep`  out  2  current step, 0 = IDLE, 1..3 = T1..T3

## Operation
- Instruction format: `ir[8:6]` = opcode, `ir[5:3]` = X, `ir[2:0]` = Y.
- Opcodes:
  - 000 `mv Rx,Ry`
  - 001 `mvi Rx,#D`
  - 010 `add Rx,Ry`
  - 011 `sub Rx,Ry`
  - 1xx reserved, executes as NOP.
- FSM states: IDLE, T1, T2, T3, held in a 2-bit registered `tstep`.
- IDLE: all outputs 0. If `run`=1, load `ir`<=`din` and go to T1. Otherwise stay.
- T1 actions by opcode:
  - mv: `rsele[Y]`, `rin[X]`, `done`. Next state IDLE.
  - mvi: `dsele`, `rin[X]`, `done`. Next state IDLE.
  - add/sub: `rsele[X]`, `ain`. Next state T2.
  - NOP: `done` only. Next state IDLE.
- T2 (add/sub): `rsele[Y]`, `gin`, `addsub` = `ir[6]`. Next state T3.
- T3 (add/sub): `gsele`, `rin[X]`, `done`. Next state IDLE.
- All outputs are Moore: decoded combinationally from registered `tstep` and `ir` only. No path from `run` or `din` to any output.
- Invariants, checked every cycle:
  - At most one of {`rsele` bits, `gsele`, `dsele`} is high.
  - At most one `rin` bit is high.
  - `done` is high only in the final step of an instruction.
  - `addsub` is 0 outside T2.
- X = Y is legal. mv R3,R3 asserts `rsele[3]` and `rin[3]` together.
- `run` is ignored outside IDLE. `ir` is stable from the T1 entry edge until the next IDLE load.

## Timing
- Reset values: `tstep`=0 (IDLE), `ir`=9'b0, all outputs 0.
- Reset asserted in any state: next edge forces IDLE with `ir`=0. `done` is not asserted for the aborted instruction. Reset has priority over `run`.
- Latency from the `run`-sampling edge:
  - mv, mvi, NOP: `done` in the first cycle after that edge (T1).
  - add, sub: `done` in the third cycle after that edge (T3).
- Throughput: with `run` held high, one IDLE cycle separates instructions. The next `ir` load occurs on the edge that leaves IDLE.
- Immediate for mvi: memory must present data D on `din` during T1. The controller only asserts `dsele`; it does not latch D.
- Register writes occur on the edge ending the cycle in which `rin[X]` is high. Consecutive instructions therefore see updated values.

## Test plan
- Reset then idle: hold `reset`=1 for 2 cycles, then `run`=0 for 5 cycles. Expect `tstep`=0, `ir`=0 and all outputs 0 throughout.
- mvi R2,#0x15: `din`=9'b001_010_000 with `run`=1, then `din`=9'h015 in T1. Expect T1 `dsele`=1, `rin`=8'b0000_0100, `done`=1, and back in IDLE next cycle.
- mv R5,R2: `din`=9'b000_101_010. Expect T1 `rsele`=8'b0000_0100, `rin`=8'b0010_0000, `done`=1. Total cycles IDLE→IDLE = 2.
- sub R1,R6: `din`=9'b011_001_110. Expect:
  - T1: `rsele[1]`, `ain`.
  - T2: `rsele[6]`, `gin`, `addsub`=1.
  - T3: `gsele`, `rin[1]`, `done`.
  - `addsub`=0 in every other cycle.
- Back-to-back and abort: run add R0,R1 then mv R3,R3 with `run` held high. Expect one IDLE cycle between them and `rsele[3]`&`rin[3]` both high in T1. Repeat the add and assert `reset` in T2. Expect IDLE next edge, no `done`, `ir`=0.
- NOP and `run` ignore: `din`=9'b110_000_000. Expect T1 `done`=1 with all selects and enables 0. Toggle `run` and `din` during T1–T3 of an add. Expect `ir` unchanged.
